// File: rtl/adpll_pi_filter.sv
// ADPLL proportional-integral loop filter: 3-stage pipeline (gain multiply, saturating integrate, DCO word clamp).
// Optional lock-detect gear shifting between acquisition and tracking gains is enabled by ADPLL_LF_GEARSHIFT_EN.
module adpll_pi_filter #(
    parameter int ERROR_WIDTH   = 5,
    parameter int KP_WIDTH      = 5,
    parameter int KI_WIDTH      = 7,
    parameter int ACC_WIDTH     = 12,
    parameter int DCO_CC_WIDTH  = 5,
    parameter int P_SHIFT       = 2,
    parameter int OUT_SHIFT     = 7,
    parameter int LOCK_THRESH   = 1,
    parameter int UNLOCK_THRESH = 4,
    parameter int LOCK_COUNT    = 8
) (
    input  logic                           gen_clk_i,
    input  logic                           reset_i,
    input  logic                           error_valid_i,
    input  logic signed [ERROR_WIDTH-1:0]  error_i,
    input  logic        [KP_WIDTH-1:0]     kp_acq_i,
    input  logic        [KI_WIDTH-1:0]     ki_acq_i,
    input  logic        [KP_WIDTH-1:0]     kp_trk_i,
    input  logic        [KI_WIDTH-1:0]     ki_trk_i,
    output logic signed [DCO_CC_WIDTH-1:0] dco_cc_o,
    output logic                           dco_cc_valid_o,
    output logic                           locked_o,
    output logic                           sat_o
);

    localparam int P_W   = ERROR_WIDTH + KP_WIDTH;
    localparam int I_W   = ERROR_WIDTH + KI_WIDTH;
    localparam int A_W   = ((ACC_WIDTH > I_W) ? ACC_WIDTH : I_W) + 1;
    localparam int SUM_W = ACC_WIDTH + KP_WIDTH + ERROR_WIDTH + P_SHIFT + 1;

    localparam logic signed [A_W-1:0]   ACC_MAX_C = {{(A_W-ACC_WIDTH+1){1'b0}}, {(ACC_WIDTH-1){1'b1}}};
    localparam logic signed [A_W-1:0]   ACC_MIN_C = {{(A_W-ACC_WIDTH+1){1'b1}}, {(ACC_WIDTH-1){1'b0}}};
    localparam logic signed [SUM_W-1:0] DCO_MAX_C = {{(SUM_W-DCO_CC_WIDTH+1){1'b0}}, {(DCO_CC_WIDTH-1){1'b1}}};
    localparam logic signed [SUM_W-1:0] DCO_MIN_C = {{(SUM_W-DCO_CC_WIDTH+1){1'b1}}, {(DCO_CC_WIDTH-1){1'b0}}};

    logic [KP_WIDTH-1:0] kp_sel_s;
    logic [KI_WIDTH-1:0] ki_sel_s;

`ifdef ADPLL_LF_GEARSHIFT_EN
    localparam int CNT_W = $clog2(LOCK_COUNT + 1);
    localparam logic [0:0]           ST_ACQUIRE = 1'b0;
    localparam logic [0:0]           ST_TRACK   = 1'b1;
    localparam logic [ERROR_WIDTH:0] LOCK_TH_C   = (ERROR_WIDTH+1)'(LOCK_THRESH);
    localparam logic [ERROR_WIDTH:0] UNLOCK_TH_C = (ERROR_WIDTH+1)'(UNLOCK_THRESH);
    localparam logic [CNT_W-1:0]     LOCK_CNT_C  = CNT_W'(LOCK_COUNT);

    logic [0:0]           state_q, state_d;
    logic [CNT_W-1:0]     run_cnt_q, run_cnt_d;
    logic                 locked_q, locked_d;
    logic [ERROR_WIDTH:0] err_ext_s, err_abs_s;

    // Lock detector: gains follow the state before this sample's update.
    always_comb begin
        err_ext_s = {error_i[ERROR_WIDTH-1], error_i};
        if (error_i[ERROR_WIDTH-1]) begin
            err_abs_s = -err_ext_s;
        end else begin
            err_abs_s = err_ext_s;
        end
        state_d   = state_q;
        run_cnt_d = run_cnt_q;
        if (error_valid_i) begin
            case (state_q)
                ST_ACQUIRE: begin
                    if (err_abs_s <= LOCK_TH_C) begin
                        if (run_cnt_q + CNT_W'(1) == LOCK_CNT_C) begin
                            state_d   = ST_TRACK;
                            run_cnt_d = '0;
                        end else begin
                            run_cnt_d = run_cnt_q + CNT_W'(1);
                        end
                    end else begin
                        run_cnt_d = '0;
                    end
                end
                ST_TRACK: begin
                    if (err_abs_s > UNLOCK_TH_C) begin
                        state_d   = ST_ACQUIRE;
                        run_cnt_d = '0;
                    end else begin
                        state_d = ST_TRACK;
                    end
                end
                default: begin
                    state_d   = ST_ACQUIRE;
                    run_cnt_d = '0;
                end
            endcase
        end else begin
            state_d = state_q;
        end
        locked_d = (state_d == ST_TRACK);
        if (state_q == ST_TRACK) begin
            kp_sel_s = kp_trk_i;
            ki_sel_s = ki_trk_i;
        end else begin
            kp_sel_s = kp_acq_i;
            ki_sel_s = ki_acq_i;
        end
    end

    // Lock state registers.
    always_ff @(posedge gen_clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q   <= ST_ACQUIRE;
            run_cnt_q <= '0;
            locked_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            run_cnt_q <= run_cnt_d;
            locked_q  <= locked_d;
        end
    end

    assign locked_o = locked_q;
`else
    logic unused_trk_s;

    // Single-gear build: acquisition gains only.
    always_comb begin
        kp_sel_s = kp_acq_i;
        ki_sel_s = ki_acq_i;
    end

    assign unused_trk_s = ^{kp_trk_i, ki_trk_i};
    assign locked_o     = 1'b0;
`endif

    logic signed [P_W-1:0]          p_q, p_d;
    logic signed [I_W-1:0]          i_q, i_d;
    logic                           v1_q, v1_d;
    logic signed [ACC_WIDTH-1:0]    acc_q, acc_d;
    logic signed [SUM_W-1:0]        sum_q, sum_d;
    logic                           v2_q, v2_d;
    logic                           sat2_q, sat2_d;
    logic signed [DCO_CC_WIDTH-1:0] dco_q, dco_d;
    logic                           dco_vld_q, dco_vld_d;
    logic                           sat_q, sat_d;

    logic signed [P_W-1:0]       err_p_s, kp_p_s;
    logic signed [I_W-1:0]       err_i_s, ki_i_s;
    logic signed [A_W-1:0]       acc_sum_s;
    logic signed [ACC_WIDTH-1:0] acc_new_s;
    logic                        acc_clip_s;
    logic signed [SUM_W-1:0]     p_al_s, shifted_s;
    logic signed [DCO_CC_WIDTH-1:0] dco_new_s;

    // Stage 1: gain products; stage 2: saturating integrator and sum.
    always_comb begin
        err_p_s = {{KP_WIDTH{error_i[ERROR_WIDTH-1]}}, error_i};
        kp_p_s  = {{ERROR_WIDTH{1'b0}}, kp_sel_s};
        err_i_s = {{KI_WIDTH{error_i[ERROR_WIDTH-1]}}, error_i};
        ki_i_s  = {{ERROR_WIDTH{1'b0}}, ki_sel_s};
        v1_d    = error_valid_i;
        if (error_valid_i) begin
            p_d = err_p_s * kp_p_s;
            i_d = err_i_s * ki_i_s;
        end else begin
            p_d = p_q;
            i_d = i_q;
        end

        acc_sum_s = {{(A_W-ACC_WIDTH){acc_q[ACC_WIDTH-1]}}, acc_q}
                  + {{(A_W-I_W){i_q[I_W-1]}}, i_q};
        if (acc_sum_s > ACC_MAX_C) begin
            acc_new_s  = ACC_MAX_C[ACC_WIDTH-1:0];
            acc_clip_s = 1'b1;
        end else if (acc_sum_s < ACC_MIN_C) begin
            acc_new_s  = ACC_MIN_C[ACC_WIDTH-1:0];
            acc_clip_s = 1'b1;
        end else begin
            acc_new_s  = acc_sum_s[ACC_WIDTH-1:0];
            acc_clip_s = 1'b0;
        end
        p_al_s = {{(SUM_W-P_W){p_q[P_W-1]}}, p_q} <<< P_SHIFT;
        v2_d   = v1_q;
        if (v1_q) begin
            acc_d  = acc_new_s;
            sum_d  = p_al_s + {{(SUM_W-ACC_WIDTH){acc_new_s[ACC_WIDTH-1]}}, acc_new_s};
            sat2_d = acc_clip_s;
        end else begin
            acc_d  = acc_q;
            sum_d  = sum_q;
            sat2_d = sat2_q;
        end
    end

    // Stage 3: floor-scaled, clamped DCO word.
    always_comb begin
        shifted_s = sum_q >>> OUT_SHIFT;
        if (shifted_s > DCO_MAX_C) begin
            dco_new_s = DCO_MAX_C[DCO_CC_WIDTH-1:0];
        end else if (shifted_s < DCO_MIN_C) begin
            dco_new_s = DCO_MIN_C[DCO_CC_WIDTH-1:0];
        end else begin
            dco_new_s = shifted_s[DCO_CC_WIDTH-1:0];
        end
        dco_vld_d = v2_q;
        if (v2_q) begin
            dco_d = dco_new_s;
            sat_d = sat2_q;
        end else begin
            dco_d = dco_q;
            sat_d = sat_q;
        end
    end

    // Datapath pipeline registers.
    always_ff @(posedge gen_clk_i or posedge reset_i) begin
        if (reset_i) begin
            p_q       <= '0;
            i_q       <= '0;
            v1_q      <= 1'b0;
            acc_q     <= '0;
            sum_q     <= '0;
            v2_q      <= 1'b0;
            sat2_q    <= 1'b0;
            dco_q     <= '0;
            dco_vld_q <= 1'b0;
            sat_q     <= 1'b0;
        end else begin
            p_q       <= p_d;
            i_q       <= i_d;
            v1_q      <= v1_d;
            acc_q     <= acc_d;
            sum_q     <= sum_d;
            v2_q      <= v2_d;
            sat2_q    <= sat2_d;
            dco_q     <= dco_d;
            dco_vld_q <= dco_vld_d;
            sat_q     <= sat_d;
        end
    end

    assign dco_cc_o       = dco_q;
    assign dco_cc_valid_o = dco_vld_q;
    assign sat_o          = sat_q;

endmodule

// File: tb/tb_adpll_pi_filter.sv
// Self-checking bench for adpll_pi_filter; reference model computes each result with integer arithmetic.
// Honours ADPLL_LF_GEARSHIFT_EN the same way as the design.
module tb_adpll_pi_filter;

    localparam int ACC_MAX = 2047;
    localparam int ACC_MIN = -2048;
    localparam int P_MUL   = 4;
    localparam int OUT_DIV = 128;

    logic              clk = 1'b0;
    logic              reset_i;
    logic              error_valid_i;
    logic signed [4:0] error_i;
    logic        [4:0] kp_acq_i, kp_trk_i;
    logic        [6:0] ki_acq_i, ki_trk_i;
    logic signed [4:0] dco_cc_o;
    logic              dco_cc_valid_o, locked_o, sat_o;

    int tests = 0;
    int fails = 0;

    // Reference model state and a two-deep delay line of pending results.
    int m_acc, m_mode, m_cnt;
    bit q1_v, q2_v, q1_sat, q2_sat;
    int q1_dco, q2_dco;
    int exp_dco, exp_locked;
    bit exp_vld, exp_sat;

    adpll_pi_filter dut (
        .gen_clk_i      (clk),
        .reset_i        (reset_i),
        .error_valid_i  (error_valid_i),
        .error_i        (error_i),
        .kp_acq_i       (kp_acq_i),
        .ki_acq_i       (ki_acq_i),
        .kp_trk_i       (kp_trk_i),
        .ki_trk_i       (ki_trk_i),
        .dco_cc_o       (dco_cc_o),
        .dco_cc_valid_o (dco_cc_valid_o),
        .locked_o       (locked_o),
        .sat_o          (sat_o)
    );

    always #5 clk = ~clk;

    function automatic int floor_div(input int a, input int b);
        if (a >= 0) return a / b;
        return -((-a + b - 1) / b);
    endfunction

    function automatic int clampi(input int v, input int lo, input int hi);
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

    task automatic model_reset();
        m_acc = 0; m_mode = 0; m_cnt = 0;
        q1_v = 0; q2_v = 0; q1_sat = 0; q2_sat = 0; q1_dco = 0; q2_dco = 0;
        exp_dco = 0; exp_locked = 0; exp_vld = 0; exp_sat = 0;
    endtask

    task automatic do_reset();
        error_valid_i = 1'b0;
        error_i       = 5'sd0;
        reset_i       = 1'b1;
        @(posedge clk);
        #1;
        reset_i = 1'b0;
        model_reset();
    endtask

    // One clock: drive inputs, advance the reference model at the edge, sample 1 time unit later.
    task automatic step(input bit v, input int e);
        int kp, ki, mag, sum, raw;
        error_valid_i = v;
        error_i       = e[4:0];
        @(posedge clk);
        exp_vld = q2_v;
        if (q2_v) begin
            exp_dco = q2_dco;
            exp_sat = q2_sat;
        end
        q2_v = q1_v; q2_dco = q1_dco; q2_sat = q1_sat;
        q1_v = v;
        if (v) begin
            kp = (m_mode == 1) ? int'(kp_trk_i) : int'(kp_acq_i);
            ki = (m_mode == 1) ? int'(ki_trk_i) : int'(ki_acq_i);
            raw    = m_acc + e * ki;
            m_acc  = clampi(raw, ACC_MIN, ACC_MAX);
            q1_sat = (raw != m_acc);
            sum    = e * kp * P_MUL + m_acc;
            q1_dco = clampi(floor_div(sum, OUT_DIV), -16, 15);
`ifdef ADPLL_LF_GEARSHIFT_EN
            mag = (e < 0) ? -e : e;
            if (m_mode == 0) begin
                if (mag <= 1) begin
                    m_cnt++;
                    if (m_cnt == 8) begin m_mode = 1; m_cnt = 0; end
                end else begin
                    m_cnt = 0;
                end
            end else if (mag > 4) begin
                m_mode = 0; m_cnt = 0;
            end
`else
            mag = 0;
`endif
        end
        exp_locked = m_mode;
        #1;
    endtask

    task automatic test_reset();
        reset_i = 1'b1; error_valid_i = 1'b0; error_i = 5'sd0;
        #12;
        tests++; if (dco_cc_o !== 5'sd0) begin fails++; $display("FAIL reset_dco: got %0d want 0", dco_cc_o); end
        tests++; if (dco_cc_valid_o !== 1'b0) begin fails++; $display("FAIL reset_vld: got %b want 0", dco_cc_valid_o); end
        tests++; if (sat_o !== 1'b0) begin fails++; $display("FAIL reset_sat: got %b want 0", sat_o); end
        tests++; if (locked_o !== 1'b0) begin fails++; $display("FAIL reset_locked: got %b want 0", locked_o); end
        @(posedge clk); #1;
        reset_i = 1'b0;
        model_reset();
        kp_acq_i = 5'd31; ki_acq_i = 7'd100; kp_trk_i = 5'd0; ki_trk_i = 7'd0;
        for (int n = 0; n < 4; n++) step(1'b1, 15);
        tests++; if (dco_cc_o === 5'sd0) begin fails++; $display("FAIL premid_dco: got %0d want nonzero", dco_cc_o); end
        #2 reset_i = 1'b1;
        #1;
        tests++; if (dco_cc_o !== 5'sd0) begin fails++; $display("FAIL midreset_dco: got %0d want 0", dco_cc_o); end
        tests++; if (dco_cc_valid_o !== 1'b0) begin fails++; $display("FAIL midreset_vld: got %b want 0", dco_cc_valid_o); end
        tests++; if (sat_o !== 1'b0) begin fails++; $display("FAIL midreset_sat: got %b want 0", sat_o); end
        @(posedge clk); #1;
        reset_i = 1'b0;
        model_reset();
        for (int n = 0; n < 4; n++) begin
            step(1'b0, 0);
            tests++; if (dco_cc_valid_o !== 1'b0) begin fails++; $display("FAIL stale_vld[%0d]: got %b want 0", n, dco_cc_valid_o); end
        end
    endtask

    task automatic test_proportional();
        do_reset();
        kp_acq_i = 5'd31; ki_acq_i = 7'd1;
        step(1'b1, 8);
        step(1'b0, 0);
        tests++; if (dco_cc_valid_o !== 1'b0) begin fails++; $display("FAIL early_vld: got %b want 0", dco_cc_valid_o); end
        step(1'b0, 0);
        tests++; if (dco_cc_valid_o !== 1'b1) begin fails++; $display("FAIL p_pos_vld: got %b want 1", dco_cc_valid_o); end
        tests++; if (dco_cc_o !== 5'sd7) begin fails++; $display("FAIL p_pos_dco: got %0d want 7", dco_cc_o); end
        step(1'b0, 0);
        tests++; if (dco_cc_valid_o !== 1'b0) begin fails++; $display("FAIL pulse_len: got %b want 0", dco_cc_valid_o); end
        tests++; if (dco_cc_o !== 5'sd7) begin fails++; $display("FAIL hold_dco: got %0d want 7", dco_cc_o); end
        do_reset();
        kp_acq_i = 5'd31; ki_acq_i = 7'd0;
        step(1'b1, -8);
        step(1'b0, 0);
        step(1'b0, 0);
        tests++; if (dco_cc_o !== -5'sd8) begin fails++; $display("FAIL p_neg_dco: got %0d want -8", dco_cc_o); end
    endtask

    task automatic test_saturation();
        do_reset();
        kp_acq_i = 5'd0; ki_acq_i = 7'd1;
        for (int n = 1; n <= 141; n++) begin
            step(1'b1, 15);
            if (n == 138) begin
                tests++; if (sat_o !== 1'b0) begin fails++; $display("FAIL sat_136: got %b want 0", sat_o); end
            end else if (n == 139) begin
                tests++; if (sat_o !== 1'b1) begin fails++; $display("FAIL sat_137: got %b want 1", sat_o); end
                tests++; if (dco_cc_o !== 5'sd15) begin fails++; $display("FAIL sat_dco: got %0d want 15", dco_cc_o); end
            end else if (n > 2) begin
                tests++; if (dco_cc_o !== exp_dco || sat_o !== exp_sat) begin
                    fails++; $display("FAIL integ[%0d]: got dco %0d sat %b want dco %0d sat %b", n, dco_cc_o, sat_o, exp_dco, exp_sat);
                end
            end
        end
        tests++; if (dco_cc_o !== 5'sd15) begin fails++; $display("FAIL no_wrap: got %0d want 15", dco_cc_o); end
    endtask

    task automatic test_gearshift();
        do_reset();
        kp_acq_i = 5'd0; ki_acq_i = 7'd0; kp_trk_i = 5'd31; ki_trk_i = 7'd100;
        for (int n = 1; n <= 8; n++) begin
            step(1'b1, 0);
            tests++; if (locked_o !== 1'(exp_locked)) begin fails++; $display("FAIL lock_run[%0d]: got %b want %0d", n, locked_o, exp_locked); end
        end
`ifdef ADPLL_LF_GEARSHIFT_EN
        tests++; if (locked_o !== 1'b1) begin fails++; $display("FAIL lock_8th: got %b want 1", locked_o); end
`else
        tests++; if (locked_o !== 1'b0) begin fails++; $display("FAIL nolock_8th: got %b want 0", locked_o); end
`endif
        step(1'b1, 1);
        step(1'b0, 0);
        step(1'b0, 0);
        tests++; if (dco_cc_o !== 5'(exp_dco)) begin fails++; $display("FAIL trk_gain_dco: got %0d want %0d", dco_cc_o, exp_dco); end
`ifdef ADPLL_LF_GEARSHIFT_EN
        tests++; if (dco_cc_o !== 5'sd1) begin fails++; $display("FAIL trk_gain_const: got %0d want 1", dco_cc_o); end
`else
        tests++; if (dco_cc_o !== 5'sd0) begin fails++; $display("FAIL acq_gain_const: got %0d want 0", dco_cc_o); end
`endif
        step(1'b1, 5);
        tests++; if (locked_o !== 1'b0) begin fails++; $display("FAIL unlock_p5: got %b want 0", locked_o); end
        for (int n = 1; n <= 8; n++) begin
            step(1'b1, 0);
            tests++; if (locked_o !== 1'(exp_locked)) begin fails++; $display("FAIL relock[%0d]: got %b want %0d", n, locked_o, exp_locked); end
        end
    endtask

    task automatic test_lock_break();
        do_reset();
        kp_acq_i = 5'd3; ki_acq_i = 7'd5; kp_trk_i = 5'd7; ki_trk_i = 7'd9;
        for (int n = 0; n < 15; n++) begin
            step(1'b1, (n == 7) ? 2 : 0);
            tests++; if (locked_o !== 1'b0) begin fails++; $display("FAIL break_run[%0d]: got %b want 0", n, locked_o); end
        end
        step(1'b1, 0);
        tests++; if (locked_o !== 1'(exp_locked)) begin fails++; $display("FAIL break_relock: got %b want %0d", locked_o, exp_locked); end
        step(1'b1, -16);
        tests++; if (locked_o !== 1'b0) begin fails++; $display("FAIL unlock_m16: got %b want 0", locked_o); end
    endtask

    task automatic test_back_to_back_random();
        int e;
        bit v;
        do_reset();
        for (int n = 0; n < 600; n++) begin
            kp_acq_i = 5'($urandom); ki_acq_i = 7'($urandom);
            kp_trk_i = 5'($urandom); ki_trk_i = 7'($urandom);
            if ($urandom_range(0, 9) < ((n < 300) ? 9 : 4)) e = int'($urandom_range(0, 2)) - 1;
            else e = int'($urandom_range(0, 31)) - 16;
            v = ($urandom_range(0, 9) < 8);
            step(v, e);
            tests++; if (dco_cc_valid_o !== exp_vld) begin fails++; $display("FAIL rnd_vld[%0d]: got %b want %b", n, dco_cc_valid_o, exp_vld); end
            tests++; if (dco_cc_o !== 5'(exp_dco)) begin fails++; $display("FAIL rnd_dco[%0d]: got %0d want %0d", n, dco_cc_o, exp_dco); end
            tests++; if (sat_o !== exp_sat) begin fails++; $display("FAIL rnd_sat[%0d]: got %b want %b", n, sat_o, exp_sat); end
            tests++; if (locked_o !== 1'(exp_locked)) begin fails++; $display("FAIL rnd_lock[%0d]: got %b want %0d", n, locked_o, exp_locked); end
        end
    endtask

    initial begin
        kp_acq_i = 5'd0; ki_acq_i = 7'd0; kp_trk_i = 5'd0; ki_trk_i = 7'd0;
        model_reset();
        test_reset();
        test_proportional();
        test_saturation();
        test_gearshift();
        test_lock_break();
        test_back_to_back_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/adpll_pi_filter.md
ADPLL_PI_FILTER -- requirements
Module: adpll_pi_filter

Interface
REQ-001 SHALL have parameter ERROR_WIDTH, default 5, phase-error width (signed).
REQ-002 SHALL have parameter KP_WIDTH, default 5, proportional gain width (unsigned).
REQ-003 SHALL have parameter KI_WIDTH, default 7, integral gain width (unsigned).
REQ-004 SHALL have parameter ACC_WIDTH, default 12, integrator width (signed).
REQ-005 SHALL have parameter DCO_CC_WIDTH, default 5, DCO control word width (signed).
REQ-006 SHALL have parameter P_SHIFT, default 2, left shift aligning proportional term to integrator.
REQ-007 SHALL have parameter OUT_SHIFT, default 7, arithmetic right shift from sum to DCO word.
REQ-008 SHALL have parameters LOCK_THRESH 1, UNLOCK_THRESH 4, LOCK_COUNT 8: lock-detect magnitudes and run length.
REQ-009 SHALL have ports: gen_clk_i in 1 clock; reset_i in 1 reset, asynchronous, active-high.
REQ-010 SHALL have ports: error_valid_i in 1 sample strobe; error_i in ERROR_WIDTH signed phase error.
REQ-011 SHALL have ports: kp_acq_i in KP_WIDTH, ki_acq_i in KI_WIDTH acquisition gains; kp_trk_i in KP_WIDTH, ki_trk_i in KI_WIDTH tracking gains.
REQ-012 SHALL have ports: dco_cc_o out DCO_CC_WIDTH signed control word; dco_cc_valid_o out 1 update strobe; locked_o out 1 tracking mode; sat_o out 1 integrator clamped.

Function
REQ-013 Stage 1 SHALL, on error_valid_i, register p = error_i*kp and i = error_i*ki (gains zero-extended, products signed, full width) with gains chosen by current mode.
REQ-014 Stage 2 SHALL, one cycle after stage 1, update acc = sat(acc + i) to ACC_WIDTH range [-2^(ACC_WIDTH-1), 2^(ACC_WIDTH-1)-1] (anti-windup, no wrap).
REQ-015 Stage 2 SHALL compute sum = (p <<< P_SHIFT) + new acc at ACC_WIDTH+KP_WIDTH+ERROR_WIDTH+P_SHIFT+1 bits, no overflow.
REQ-016 dco_cc_o SHALL register sat(sum >>> OUT_SHIFT) clamped to DCO_CC_WIDTH signed range (floor rounding).
REQ-017 dco_cc_o and dco_cc_valid_o (1-cycle pulse) SHALL update exactly 2 cycles after the accepting error_valid_i edge; back-to-back valid samples fully pipelined, one result per cycle.
REQ-018 Cycles without error_valid_i SHALL hold acc, dco_cc_o, mode and lock counter unchanged.
REQ-019 sat_o SHALL register 1 when the latest acc update clamped, else 0; updates with dco_cc_valid_o.
REQ-020 Lock FSM states ACQUIRE, TRACK; |error_i| computed at ERROR_WIDTH+1 bits (|-2^(ERROR_WIDTH-1)| representable).
REQ-021 In ACQUIRE, valid sample with |error_i| <= LOCK_THRESH SHALL increment run counter, else clear it; counter reaching LOCK_COUNT SHALL enter TRACK and clear counter.
REQ-022 In TRACK, valid sample with |error_i| > UNLOCK_THRESH SHALL return to ACQUIRE, counter cleared; otherwise stay.
REQ-023 Mode change SHALL take effect for the next valid sample; the triggering sample uses old-mode gains.
REQ-024 locked_o SHALL equal (state == TRACK), registered.
REQ-025 Gain input changes SHALL be sampled only on valid cycles; no retained gain state.

Reset
REQ-026 reset_i SHALL asynchronously clear p, i, acc, dco_cc_o, dco_cc_valid_o, sat_o, locked_o, run counter, pipeline valids; state = ACQUIRE.
REQ-027 Reset mid-pipeline SHALL discard in-flight samples; no dco_cc_valid_o pulse for them after release.

Configuration
REQ-028 Macro ADPLL_LF_GEARSHIFT_EN defined: lock FSM and tracking gains active per REQ-020..REQ-024.
REQ-029 Macro undefined: no FSM/counter logic, acquisition gains always used, kp_trk_i/ki_trk_i ignored, locked_o tied 0.

Verification (defaults, macro defined unless noted)
REQ-030 Reset asserted mid-stream -> all outputs 0 immediately, state ACQUIRE, no stale valid pulse after release.
REQ-031 error_i=+8, kp_acq=31, ki_acq=1, one valid -> 2 cycles later dco_cc_o=7 (sum 992+8=1000), dco_cc_valid_o one pulse; error_i=-8, kp=31, ki=0 from reset -> dco_cc_o=-8.
REQ-032 error_i=+15, kp=0, ki=1, continuous valid -> acc 2040 after 136 samples, 2047 and sat_o=1 on 137th, dco_cc_o=15 steady, no wrap.
REQ-033 8 consecutive valid error_i=0 -> locked_o=1 after 8th; 9th sample uses kp_trk/ki_trk; then error_i=+5 -> locked_o=0, counter cleared.
REQ-034 7 samples error_i=0, 1 sample error_i=+2, 7 more error_i=0 -> locked_o stays 0; error_i=-16 in TRACK -> unlock.
REQ-035 Macro undefined, same stimulus as REQ-033 -> locked_o 0 throughout, acquisition gains used for all samples.
